// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a word-addressed data memory.
// Big-endian lane mapping; sub-word stores use a two-cycle read-modify-write.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLhu = 3'd2;
  localparam logic [2:0] OpLb  = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSb  = 3'd7;

  typedef enum logic [0:0] {StIdle, StMerge} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [15:0]         sdata_q, sdata_d;
  logic [1:0]          off_q, off_d;
  logic                half_q, half_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                load_valid_q, load_valid_d;
  logic                misaligned_q, misaligned_d;

  logic                aligned;
  logic                is_load;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   ext_data;
  logic [DATA_W-1:0]   merged;
  logic [ADDR_W-1:0]   req_word_addr;

  assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign is_load       = (req_op <= OpLbu);

  always_comb begin
    case (req_op)
      OpLw, OpSw:        aligned = (req_addr[1:0] == 2'b00);
      OpLh, OpLhu, OpSh: aligned = ~req_addr[0];
      default:           aligned = 1'b1;
    endcase
  end

  // Offset 0 is the most significant lane, so the shift is (3 - offset) bytes.
  always_comb begin
    byte_sel = 8'(mem_rdata >> {~req_addr[1:0], 3'b000});
    half_sel = req_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (req_op)
      OpLh:    ext_data = {{16{half_sel[15]}}, half_sel};
      OpLhu:   ext_data = {16'h0000, half_sel};
      OpLb:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   ext_data = {24'h000000, byte_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (half_q) begin
      if (off_q[1]) merged[15:0]  = sdata_q;
      else          merged[31:16] = sdata_q;
    end else begin
      unique case (off_q)
        2'd0: merged[31:24] = sdata_q[7:0];
        2'd1: merged[23:16] = sdata_q[7:0];
        2'd2: merged[15:8]  = sdata_q[7:0];
        2'd3: merged[7:0]   = sdata_q[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    sdata_d      = sdata_q;
    off_d        = off_q;
    half_d       = half_q;
    waddr_d      = waddr_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    stall        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;
    mem_addr     = req_word_addr;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!aligned) begin
            misaligned_d = 1'b1;
          end else if (is_load) begin
            mem_read     = 1'b1;
            load_valid_d = 1'b1;
            load_data_d  = ext_data;
          end else if (req_op == OpSw) begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            word_d   = mem_rdata;
            sdata_d  = req_wdata[15:0];
            off_d    = req_addr[1:0];
            half_d   = (req_op == OpSh);
            waddr_d  = req_word_addr;
            state_d  = StMerge;
          end
        end
      end
      StMerge: begin
        mem_addr  = waddr_q;
        mem_write = 1'b1;
        mem_wdata = merged;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset blocks the pending merge write so memory never sees a partial store.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      stall     = 1'b0;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      word_q       <= '0;
      sdata_q      <= '0;
      off_q        <= '0;
      half_q       <= 1'b0;
      waddr_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      sdata_q      <= sdata_d;
      off_q        <= off_d;
      half_q       <= half_d;
      waddr_q      <= waddr_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-word behavioural data memory.
module tb_mem_access_unit;

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLhu = 3'd2;
  localparam logic [2:0] OpLb  = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSb  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic        preload;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misaligned (misaligned),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < 6) ? 32'(i) : 32'h0;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    #1;
  endtask

  task automatic load_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp,
                         input string name);
    drive(op, addr, 32'h5A5A_5A5A);
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b100) begin
      errors++;
      $display("FAIL %s enables got rd/wr/stall=%b want 100", name, {mem_read, mem_write, stall});
    end
    checks++;
    if (mem_addr !== {addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s mem_addr got %h want %h", name, mem_addr, {addr[31:2], 2'b00});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (load_valid !== 1'b1 || load_data !== exp) begin
      errors++;
      $display("FAIL %s load got valid=%b data=%h want valid=1 data=%h", name, load_valid,
               load_data, exp);
    end
  endtask

  task automatic sub_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_word, input string name);
    drive(op, addr, data);
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b101) begin
      errors++;
      $display("FAIL %s read phase rd/wr/stall=%b want 101", name, {mem_read, mem_write, stall});
    end
    @(posedge clk); #1;
    // Scramble the request bus: the merge must rely on its latched copies.
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h0;
    #1;
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b010 || mem_wdata !== exp_word ||
        mem_addr !== {addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s merge rd/wr/stall=%b wdata=%h addr=%h want 010 %h %h", name,
               {mem_read, mem_write, stall}, mem_wdata, mem_addr, exp_word,
               {addr[31:2], 2'b00});
    end
    @(posedge clk); #1;
    checks++;
    if (mem[addr[9:2]] !== exp_word || mem_write !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s commit word=%h wr=%b stall=%b want %h 0 0", name, mem[addr[9:2]],
               mem_write, stall, exp_word);
    end
  endtask

  task automatic bad_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] word,
                        input string name);
    drive(op, addr, 32'hDEAD_BEEF);
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b000) begin
      errors++;
      $display("FAIL %s enables rd/wr/stall=%b want 000", name, {mem_read, mem_write, stall});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (misaligned !== 1'b1 || load_valid !== 1'b0 || mem[addr[9:2]] !== word) begin
      errors++;
      $display("FAIL %s result mis=%b lv=%b word=%h want 1 0 %h", name, misaligned, load_valid,
               mem[addr[9:2]], word);
    end
    @(posedge clk); #1;
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse got misaligned=%b want 0", name, misaligned);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; preload = 1'b1; req_valid = 1'b0;
    req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; preload = 1'b0;
    #1;
    checks++;
    if ({stall, load_valid, misaligned, mem_write, mem_read} !== 5'b0 || load_data !== 32'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs flags=%b ld=%h addr=%h wd=%h want all zero",
               {stall, load_valid, misaligned, mem_write, mem_read}, load_data, mem_addr,
               mem_wdata);
    end
  endtask

  task automatic test_reset_in_merge;
    drive(OpSb, 32'h4, 32'h55);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_merge stall got %b want 1", stall);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b000) begin
      errors++;
      $display("FAIL rst_merge enables rd/wr/stall=%b want 000", {mem_read, mem_write, stall});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem[1] !== 32'h1 || load_data !== 32'h0 ||
        {load_valid, misaligned, stall, mem_write, mem_read} !== 5'b0) begin
      errors++;
      $display("FAIL rst_merge after word1=%h ld=%h flags=%b want 1 0 0", mem[1], load_data,
               {load_valid, misaligned, stall, mem_write, mem_read});
    end
    load_op(OpLw, 32'h4, 32'h0000_0001, "rst_merge_lw_4");
  endtask

  task automatic test_back_to_back;
    drive(OpSw, 32'h14, 32'hCAFE_F00D);
    checks++;
    if ({mem_read, mem_write, stall} !== 3'b010 || mem_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL sw_14 rd/wr/stall=%b wdata=%h want 010 cafef00d",
               {mem_read, mem_write, stall}, mem_wdata);
    end
    load_op(OpLw, 32'h14, 32'hCAFE_F00D, "b2b_lw_14");
    load_op(OpLbu, 32'h17, 32'h0000_000D, "b2b_lbu_17");
    sub_store(OpSb, 32'h16, 32'h0000_0011, 32'hCAFE_110D, "b2b_sb_16");
    load_op(OpLh, 32'h14, 32'hFFFF_CAFE, "b2b_lh_14");
  endtask

  initial begin
    test_reset;
    load_op(OpLw, 32'h8, 32'h0000_0002, "lw_8");
    test_reset_in_merge;
    // store byte
    sub_store(OpSb, 32'h5, 32'h0000_00AB, 32'h00AB_0001, "sb_5");
    load_op(OpLw, 32'h4, 32'h00AB_0001, "lw_4");
    // byte loads
    sub_store(OpSb, 32'h10, 32'h0000_00F0, 32'hF000_0004, "sb_10");
    load_op(OpLb, 32'h10, 32'hFFFF_FFF0, "lb_10");
    load_op(OpLbu, 32'h10, 32'h0000_00F0, "lbu_10");
    load_op(OpLb, 32'h13, 32'h0000_0004, "lb_13");
    load_op(OpLb, 32'h11, 32'h0000_0000, "lb_11");
    // halfword stores and loads
    sub_store(OpSh, 32'hE, 32'h0000_1234, 32'h0000_1234, "sh_e");
    load_op(OpLh, 32'hC, 32'h0000_0000, "lh_c");
    load_op(OpLhu, 32'hE, 32'h0000_1234, "lhu_e");
    sub_store(OpSh, 32'h8, 32'h0000_8001, 32'h8001_0002, "sh_8");
    load_op(OpLh, 32'h8, 32'hFFFF_8001, "lh_8");
    load_op(OpLhu, 32'h8, 32'h0000_8001, "lhu_8");
    load_op(OpLh, 32'h10, 32'hFFFF_F000, "lh_10");
    // misaligned requests
    bad_op(OpLw, 32'h6, 32'h00AB_0001, "mis_lw_6");
    bad_op(OpSh, 32'h9, 32'h8001_0002, "mis_sh_9");
    bad_op(OpSw, 32'h2, 32'h0000_0000, "mis_sw_2");
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the EX/MEM pipeline register and the word-addressed data memory (256 x 32, combinational read, posedge write, word index = addr[9:2]).
- Turns MIPS LW/LH/LHU/LB/LBU/SW/SH/SB requests into whole-word memory accesses.
- Loads: aligns and sign- or zero-extends the read word.
- Sub-word stores: two-cycle read-modify-write, with a one-cycle pipeline stall.
- Detects misaligned accesses and suppresses them.

Parameters:
- ADDR_W, 32, width of byte address.
- DATA_W, 32, data word width (fixed 32; byte-lane logic assumes 4 lanes).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  memory request present this cycle
- req_op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- stall  output  1  hold EX/MEM and upstream stages this cycle
- load_data  output  32  registered, extended load result
- load_valid  output  1  registered, one-cycle pulse, load_data valid
- misaligned  output  1  registered, one-cycle pulse, request rejected
- mem_addr  output  32  address to data memory (word-aligned: req_addr with [1:0]=0)
- mem_wdata  output  32  write word to data memory
- mem_write  output  1  data memory write enable
- mem_read  output  1  data memory read enable
- mem_rdata  input  32  data memory read word (combinational)

Behaviour:
- Byte order: big-endian. Byte offset 0 maps to bits 31:24, offset 3 to bits 7:0. Halfword offset 0 maps to 31:16, offset 2 to 15:0.
- Alignment rules:
  - LW/SW require addr[1:0]==0.
  - LH/LHU/SH require addr[0]==0.
  - Bytes are always aligned.
- A misaligned request is suppressed:
  - mem_read and mem_write stay 0 and stall stays 0.
  - misaligned=1 on the next cycle; load_valid stays 0.
- FSM states: IDLE, MERGE.
- IDLE, aligned load:
  - mem_read=1 combinationally.
  - On the posedge, load_data <= extracted and extended mem_rdata, and load_valid <= 1 (latency 1 cycle).
  - stall=0.
- IDLE, aligned SW:
  - mem_write=1 and mem_wdata=req_wdata combinationally; committed on that posedge.
  - stall=0.
- IDLE, aligned SH/SB:
  - mem_read=1 and stall=1.
  - At the posedge, latch mem_rdata, req_wdata[15:0 or 7:0] and the offset, then go to MERGE.
- MERGE:
  - mem_write=1.
  - mem_wdata = latched word with the target lane(s) replaced by the latched store data; other lanes unchanged.
  - stall=0. The held request retires at the end of this cycle.
  - req_valid is ignored. Next state is IDLE.
- req_valid=0 in IDLE: all mem_* enables are 0 and stall=0.
- load_valid and misaligned are single-cycle pulses, cleared by default every cycle.
- Extension rules:
  - LH/LB sign-extend from bit 15/7.
  - LHU/LBU zero-extend.
  - load_data holds its last value when load_valid=0.
- While stall=1, upstream holds req_* stable. The unit nevertheless uses latched copies in MERGE.
- Reset:
  - While rst=1, mem_write, mem_read and stall are forced to 0 combinationally. This holds even if the state is MERGE, so no partial write occurs.
  - Next state is IDLE. load_data, load_valid, misaligned and the latches are cleared to 0.
- Reset values: all outputs 0; state IDLE.
- mem_addr = {req_addr[31:2],2'b00} in IDLE and the latched word address in MERGE. Upper address bits are passed through unchecked.

Test Plan (memory preloaded with word i = i for i=0..5):
- LW 0x8 -> mem_read=1, stall=0; next cycle load_valid=1, load_data=0x00000002.
- SB 0x5 data 0x000000AB -> stall=1 for one cycle, MERGE write 0x00AB0001 to word 1; then LW 0x4 -> 0x00AB0001.
- SB 0x10 data 0xF0; then LB 0x10 -> 0xFFFFFFF0; LBU 0x10 -> 0x000000F0; LB 0x13 -> 0x00000004.
- SH 0xE data 0x00001234 -> word 3 becomes 0x00001234; LH 0xC -> 0x00000000; LHU 0xE -> 0x00001234.
- Each of LW 0x6, SH 0x9, SW 0x2 -> mem_read=mem_write=0, stall=0, next-cycle misaligned=1, memory unchanged.
- SB 0x4 accepted, rst=1 in the MERGE cycle -> mem_write=0, word 1 still 0x1, state IDLE, all outputs 0; a following LW 0x4 returns 0x00000001.
